// File: rtl/banked_regfile.sv
// banked_regfile: multi-bank register file for the decode stage.
// NBANKS banks of NREGS x XLEN registers, NRD registered read ports and
// NWR write ports. Same-cycle writes bypass to the reads. A per-register
// busy scoreboard marks registers whose producer is still in flight.
//
// Ports (vectors are port-major, port p at [p*W +: W]):
//   clk, rst_n       clock, asynchronous active-low reset
//   stall            hold read outputs and ignore writes and marks
//   bubble           capture zero operands and a clear busy flag
//   rd_addr/rd_bank  read register index and bank per read port
//   rd_data/rd_busy  registered read data and pending flag per read port
//   wr_en/wr_addr/wr_bank/wr_data  write ports, highest index wins
//   mark_en/mark_addr/mark_bank    set busy on an issued destination
module banked_regfile #(
   parameter int unsigned XLEN   = 32,
   parameter int unsigned NREGS  = 32,
   parameter int unsigned NBANKS = 2,
   parameter int unsigned NRD    = 3,
   parameter int unsigned NWR    = 2,
   parameter int unsigned AW     = $clog2(NREGS),
   parameter int unsigned BW     = (NBANKS > 1) ? $clog2(NBANKS) : 1
) (
   input  logic                  clk,
   input  logic                  rst_n,
   input  logic                  stall,
   input  logic                  bubble,
   input  logic [NRD*AW-1:0]     rd_addr,
   input  logic [NRD*BW-1:0]     rd_bank,
   output logic [NRD*XLEN-1:0]   rd_data,
   output logic [NRD-1:0]        rd_busy,
   input  logic [NWR-1:0]        wr_en,
   input  logic [NWR*AW-1:0]     wr_addr,
   input  logic [NWR*BW-1:0]     wr_bank,
   input  logic [NWR*XLEN-1:0]   wr_data,
   input  logic                  mark_en,
   input  logic [AW-1:0]         mark_addr,
   input  logic [BW-1:0]         mark_bank
);

   logic [XLEN-1:0]  mem    [NBANKS][NREGS];
   logic [NREGS-1:0] busy_q [NBANKS];

   logic [AW-1:0]    w_addr   [NWR];
   logic [BW-1:0]    w_bank   [NWR];
   logic [XLEN-1:0]  w_data   [NWR];
   logic             w_valid  [NWR];
   logic             mark_valid;

   logic [AW-1:0]    r_addr   [NRD];
   logic [BW-1:0]    r_bank   [NRD];
   logic [XLEN-1:0]  eff_data [NRD];
   logic             eff_busy [NRD];

   // Bank select may exceed NBANKS when NBANKS is not a power of two.
   function automatic logic in_range(input logic [BW-1:0] b);
      return 32'(b) < NBANKS;
   endfunction

   // Bank 0 register 0 is the hardwired zero register.
   function automatic logic is_zero_reg(input logic [BW-1:0] b, input logic [AW-1:0] a);
      return (b == '0) && (a == '0);
   endfunction

   // Write and mark qualification: stall, out-of-range bank and zero register drop them.
   always_comb begin
      for (int w = 0; w < NWR; w++) begin
         w_addr[w]  = wr_addr[w*AW +: AW];
         w_bank[w]  = wr_bank[w*BW +: BW];
         w_data[w]  = wr_data[w*XLEN +: XLEN];
         w_valid[w] = wr_en[w] && !stall && in_range(w_bank[w]) &&
                      !is_zero_reg(w_bank[w], w_addr[w]);
      end
      mark_valid = mark_en && !stall && in_range(mark_bank) &&
                   !is_zero_reg(mark_bank, mark_addr);
   end

   // Effective read value: stored value, overridden by the winning same-cycle write.
   // Ascending port order lets the highest-index matching write win.
   always_comb begin
      for (int p = 0; p < NRD; p++) begin
         r_addr[p]   = rd_addr[p*AW +: AW];
         r_bank[p]   = rd_bank[p*BW +: BW];
         eff_data[p] = '0;
         eff_busy[p] = 1'b0;
         if (in_range(r_bank[p]) && !is_zero_reg(r_bank[p], r_addr[p])) begin
            eff_data[p] = mem[r_bank[p]][r_addr[p]];
            eff_busy[p] = busy_q[r_bank[p]][r_addr[p]];
         end
         for (int w = 0; w < NWR; w++) begin
            if (w_valid[w] && (w_bank[w] == r_bank[p]) && (w_addr[w] == r_addr[p])) begin
               eff_data[p] = w_data[w];
               eff_busy[p] = 1'b0;
            end
         end
      end
   end

   // Storage and scoreboard; the mark is applied last so it beats a same-cycle clear.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         for (int b = 0; b < NBANKS; b++) begin
            for (int r = 0; r < NREGS; r++) begin
               mem[b][r] <= '0;
            end
            busy_q[b] <= '0;
         end
      end else begin
         for (int w = 0; w < NWR; w++) begin
            if (w_valid[w]) begin
               mem[w_bank[w]][w_addr[w]]    <= w_data[w];
               busy_q[w_bank[w]][w_addr[w]] <= 1'b0;
            end
         end
         if (mark_valid) begin
            busy_q[mark_bank][mark_addr] <= 1'b1;
         end
      end
   end

   // Registered read outputs; stall holds, bubble injects zeros.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         rd_data <= '0;
         rd_busy <= '0;
      end else if (!stall) begin
         for (int p = 0; p < NRD; p++) begin
            rd_data[p*XLEN +: XLEN] <= bubble ? '0 : eff_data[p];
            rd_busy[p]              <= bubble ? 1'b0 : eff_busy[p];
         end
      end
   end

endmodule

// File: tb/tb_banked_regfile.sv
// tb_banked_regfile: scoreboard bench for banked_regfile.
// Two instances: the default configuration and a 3-bank, 64-bit,
// 2-read / 1-write configuration. Expected read results are queued when
// stimulus is driven and popped and compared after the capturing edge.
module tb_banked_regfile;

   logic          clk;
   logic          rst_n;
   logic          stall;
   logic          bubble;

   // default instance: XLEN 32, NREGS 32, NBANKS 2, NRD 3, NWR 2 -> AW 5, BW 1
   logic [14:0]   rd_addr;
   logic [2:0]    rd_bank;
   logic [95:0]   rd_data;
   logic [2:0]    rd_busy;
   logic [1:0]    wr_en;
   logic [9:0]    wr_addr;
   logic [1:0]    wr_bank;
   logic [63:0]   wr_data;
   logic          mark_en;
   logic [4:0]    mark_addr;
   logic [0:0]    mark_bank;

   // sweep instance: XLEN 64, NREGS 16, NBANKS 3, NRD 2, NWR 1 -> AW 4, BW 2
   logic [7:0]    rd_addr2;
   logic [3:0]    rd_bank2;
   logic [127:0]  rd_data2;
   logic [1:0]    rd_busy2;
   logic [0:0]    wr_en2;
   logic [3:0]    wr_addr2;
   logic [1:0]    wr_bank2;
   logic [63:0]   wr_data2;
   logic          mark_en2;
   logic [3:0]    mark_addr2;
   logic [1:0]    mark_bank2;

   typedef struct {
      int          inst;
      int          port;
      logic [63:0] data;
      logic        busy;
      string       name;
   } exp_t;

   exp_t sb[$];
   int   tests = 0;
   int   fails = 0;

   banked_regfile #(.XLEN(32), .NREGS(32), .NBANKS(2), .NRD(3), .NWR(2)) dut (
      .clk(clk), .rst_n(rst_n), .stall(stall), .bubble(bubble),
      .rd_addr(rd_addr), .rd_bank(rd_bank), .rd_data(rd_data), .rd_busy(rd_busy),
      .wr_en(wr_en), .wr_addr(wr_addr), .wr_bank(wr_bank), .wr_data(wr_data),
      .mark_en(mark_en), .mark_addr(mark_addr), .mark_bank(mark_bank)
   );

   banked_regfile #(.XLEN(64), .NREGS(16), .NBANKS(3), .NRD(2), .NWR(1)) dut2 (
      .clk(clk), .rst_n(rst_n), .stall(stall), .bubble(bubble),
      .rd_addr(rd_addr2), .rd_bank(rd_bank2), .rd_data(rd_data2), .rd_busy(rd_busy2),
      .wr_en(wr_en2), .wr_addr(wr_addr2), .wr_bank(wr_bank2), .wr_data(wr_data2),
      .mark_en(mark_en2), .mark_addr(mark_addr2), .mark_bank(mark_bank2)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   function automatic logic [63:0] get_d(input int inst, input int port);
      if (inst == 0) return 64'(rd_data[port*32 +: 32]);
      return rd_data2[port*64 +: 64];
   endfunction

   function automatic logic get_b(input int inst, input int port);
      if (inst == 0) return rd_busy[port];
      return rd_busy2[port];
   endfunction

   task automatic exp_rd(input int inst, input int port, input logic [63:0] d,
                         input logic b, input string n);
      exp_t e;
      e.inst = inst; e.port = port; e.data = d; e.busy = b; e.name = n;
      sb.push_back(e);
   endtask

   task automatic idle();
      stall = 1'b0;      bubble = 1'b0;
      rd_addr = '0;      rd_bank = '0;
      wr_en = '0;        wr_addr = '0;     wr_bank = '0;   wr_data = '0;
      mark_en = 1'b0;    mark_addr = '0;   mark_bank = '0;
      rd_addr2 = '0;     rd_bank2 = '0;
      wr_en2 = '0;       wr_addr2 = '0;    wr_bank2 = '0;  wr_data2 = '0;
      mark_en2 = 1'b0;   mark_addr2 = '0;  mark_bank2 = '0;
   endtask

   task automatic set_rd(input int p, input int b, input int a);
      rd_bank[p]         = 1'(b);
      rd_addr[p*5 +: 5]  = 5'(a);
   endtask

   task automatic set_wr(input int w, input int en, input int b, input int a,
                         input logic [31:0] d);
      wr_en[w]            = 1'(en);
      wr_bank[w]          = 1'(b);
      wr_addr[w*5 +: 5]   = 5'(a);
      wr_data[w*32 +: 32] = d;
   endtask

   task automatic set_mark(input int en, input int b, input int a);
      mark_en   = 1'(en);
      mark_bank = 1'(b);
      mark_addr = 5'(a);
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic test_reset();
      exp_t e;
      logic adv;
      for (int s = 0; s < 39; s++) begin
         idle();
         adv = 1'b1;
         if (s >= 2 && s <= 6) begin
            set_rd(0, 0, 5);
            set_rd(1, 1, 3);
         end
         if (s == 0) begin
            adv = 1'b0;
            for (int p = 0; p < 3; p++) exp_rd(0, p, 64'h0, 1'b0, "reset_init");
         end else if (s == 1) begin
            rst_n = 1'b1;
            set_wr(0, 1, 0, 5, 32'hDEADBEEF);
            set_mark(1, 1, 3);
            set_rd(0, 0, 5);
            exp_rd(0, 0, 64'hDEADBEEF, 1'b0, "reset_prewrite");
         end else if (s == 2) begin
            exp_rd(0, 0, 64'hDEADBEEF, 1'b0, "reset_prestore");
            exp_rd(0, 1, 64'h0, 1'b1, "reset_premark");
         end else if (s >= 3 && s <= 6) begin
            if (s == 3) rst_n = 1'b0;
            if (s == 5) rst_n = 1'b1;
            adv = (s == 4 || s == 6);
            for (int p = 0; p < 3; p++) exp_rd(0, p, 64'h0, 1'b0, "reset_mid");
         end else begin
            set_rd(0, 0, s - 7);
            set_rd(1, 1, s - 7);
            set_rd(2, 1, 31 - (s - 7));
            for (int p = 0; p < 3; p++) exp_rd(0, p, 64'h0, 1'b0, "reset_regs");
         end
         if (adv) tick(); else #1;
         while (sb.size() > 0) begin
            e = sb.pop_front();
            tests++;
            if (get_d(e.inst, e.port) !== e.data || get_b(e.inst, e.port) !== e.busy) begin
               fails++;
               $display("FAIL %s step %0d port %0d: got data=%h busy=%b, want data=%h busy=%b",
                        e.name, s, e.port, get_d(e.inst, e.port), get_b(e.inst, e.port), e.data, e.busy);
            end
         end
      end
   endtask

   task automatic test_bypass();
      exp_t e;
      for (int s = 0; s < 5; s++) begin
         idle();
         case (s)
            0: begin
               set_wr(0, 1, 1, 0, 32'h11111111);
               set_wr(1, 1, 1, 0, 32'h22222222);
               set_rd(2, 1, 0);
               exp_rd(0, 2, 64'h22222222, 1'b0, "bypass_prio");
            end
            1: begin
               set_rd(0, 1, 0);
               set_rd(2, 1, 0);
               exp_rd(0, 0, 64'h22222222, 1'b0, "bypass_store0");
               exp_rd(0, 2, 64'h22222222, 1'b0, "bypass_store2");
            end
            2: begin
               set_wr(0, 1, 0, 0, 32'h5);
               set_rd(0, 0, 0);
               set_rd(1, 0, 0);
               exp_rd(0, 0, 64'h0, 1'b0, "zero_bypass0");
               exp_rd(0, 1, 64'h0, 1'b0, "zero_bypass1");
            end
            3: begin
               set_rd(0, 0, 0);
               exp_rd(0, 0, 64'h0, 1'b0, "zero_store");
            end
            default: begin
               set_wr(0, 1, 0, 6, 32'h60);
               set_wr(1, 1, 1, 6, 32'h6);
               set_rd(0, 1, 6);
               set_rd(1, 0, 6);
               exp_rd(0, 0, 64'h6, 1'b0, "bypass_bank1");
               exp_rd(0, 1, 64'h60, 1'b0, "bypass_bank0");
            end
         endcase
         tick();
         while (sb.size() > 0) begin
            e = sb.pop_front();
            tests++;
            if (get_d(e.inst, e.port) !== e.data || get_b(e.inst, e.port) !== e.busy) begin
               fails++;
               $display("FAIL %s step %0d port %0d: got data=%h busy=%b, want data=%h busy=%b",
                        e.name, s, e.port, get_d(e.inst, e.port), get_b(e.inst, e.port), e.data, e.busy);
            end
         end
      end
   endtask

   task automatic test_scoreboard();
      exp_t e;
      for (int s = 0; s < 9; s++) begin
         idle();
         case (s)
            0: begin
               set_mark(1, 0, 7);
               set_rd(0, 0, 7);
               exp_rd(0, 0, 64'h0, 1'b0, "mark_same_cycle");
            end
            1, 2: begin
               set_rd(0, 0, 7);
               exp_rd(0, 0, 64'h0, 1'b1, "mark_visible");
            end
            3: begin
               set_wr(0, 1, 0, 7, 32'hCAFE0007);
               set_rd(0, 0, 7);
               exp_rd(0, 0, 64'hCAFE0007, 1'b0, "clear_bypass");
            end
            4: begin
               set_rd(0, 0, 7);
               exp_rd(0, 0, 64'hCAFE0007, 1'b0, "clear_stored");
            end
            5: begin
               set_mark(1, 0, 7);
               set_wr(1, 1, 0, 7, 32'h77);
               set_rd(1, 0, 7);
               exp_rd(0, 1, 64'h77, 1'b0, "mark_write_same");
            end
            6: begin
               set_rd(1, 0, 7);
               exp_rd(0, 1, 64'h77, 1'b1, "mark_beats_clear");
            end
            7: begin
               set_mark(1, 0, 0);
               set_rd(2, 0, 0);
               exp_rd(0, 2, 64'h0, 1'b0, "mark_r0_same");
            end
            default: begin
               set_rd(2, 0, 0);
               exp_rd(0, 2, 64'h0, 1'b0, "mark_r0_dropped");
            end
         endcase
         tick();
         while (sb.size() > 0) begin
            e = sb.pop_front();
            tests++;
            if (get_d(e.inst, e.port) !== e.data || get_b(e.inst, e.port) !== e.busy) begin
               fails++;
               $display("FAIL %s step %0d port %0d: got data=%h busy=%b, want data=%h busy=%b",
                        e.name, s, e.port, get_d(e.inst, e.port), get_b(e.inst, e.port), e.data, e.busy);
            end
         end
      end
   endtask

   task automatic test_stall();
      exp_t e;
      for (int s = 0; s < 5; s++) begin
         idle();
         if (s == 0) begin
            set_wr(0, 1, 0, 9, 32'h1234);
            set_rd(0, 0, 9);
            set_rd(1, 1, 0);
            set_rd(2, 0, 7);
         end else if (s <= 3) begin
            stall = 1'b1;
            set_wr(0, 1, 0, 9, 32'hABCD);
            set_mark(1, 0, 9);
            set_rd(0, 0, 9 + s);
            set_rd(1, 0, 7);
            set_rd(2, 1, 4);
         end else begin
            set_rd(0, 0, 9);
            set_rd(1, 0, 7);
            set_rd(2, 1, 0);
         end
         if (s < 4) begin
            exp_rd(0, 0, 64'h1234, 1'b0, "stall_hold0");
            exp_rd(0, 1, 64'h22222222, 1'b0, "stall_hold1");
            exp_rd(0, 2, 64'h77, 1'b1, "stall_hold2");
         end else begin
            exp_rd(0, 0, 64'h1234, 1'b0, "stall_no_write");
            exp_rd(0, 1, 64'h77, 1'b1, "stall_after1");
            exp_rd(0, 2, 64'h22222222, 1'b0, "stall_after2");
         end
         tick();
         while (sb.size() > 0) begin
            e = sb.pop_front();
            tests++;
            if (get_d(e.inst, e.port) !== e.data || get_b(e.inst, e.port) !== e.busy) begin
               fails++;
               $display("FAIL %s step %0d port %0d: got data=%h busy=%b, want data=%h busy=%b",
                        e.name, s, e.port, get_d(e.inst, e.port), get_b(e.inst, e.port), e.data, e.busy);
            end
         end
      end
   endtask

   task automatic test_bubble();
      exp_t e;
      for (int s = 0; s < 5; s++) begin
         idle();
         case (s)
            0: begin
               bubble = 1'b1;
               set_wr(0, 1, 1, 4, 32'h3F800000);
               set_mark(1, 0, 2);
               set_rd(0, 1, 4);
               set_rd(1, 0, 2);
               set_rd(2, 0, 9);
               for (int p = 0; p < 3; p++) exp_rd(0, p, 64'h0, 1'b0, "bubble_zero");
            end
            1, 2: begin
               if (s == 2) begin
                  stall  = 1'b1;
                  bubble = 1'b1;
               end else begin
                  set_rd(0, 1, 4);
                  set_rd(1, 0, 2);
                  set_rd(2, 0, 9);
               end
               exp_rd(0, 0, 64'h3F800000, 1'b0, "bubble_write");
               exp_rd(0, 1, 64'h0, 1'b1, "bubble_mark");
               exp_rd(0, 2, 64'h1234, 1'b0, "bubble_other");
            end
            3: begin
               bubble = 1'b1;
               set_wr(1, 1, 0, 2, 32'h2222);
               set_rd(1, 0, 2);
               exp_rd(0, 1, 64'h0, 1'b0, "bubble_clear");
            end
            default: begin
               set_rd(1, 0, 2);
               exp_rd(0, 1, 64'h2222, 1'b0, "bubble_cleared");
            end
         endcase
         tick();
         while (sb.size() > 0) begin
            e = sb.pop_front();
            tests++;
            if (get_d(e.inst, e.port) !== e.data || get_b(e.inst, e.port) !== e.busy) begin
               fails++;
               $display("FAIL %s step %0d port %0d: got data=%h busy=%b, want data=%h busy=%b",
                        e.name, s, e.port, get_d(e.inst, e.port), get_b(e.inst, e.port), e.data, e.busy);
            end
         end
      end
   endtask

   // Random traffic on a few registers against a behavioural model.
   task automatic test_back_to_back();
      exp_t        e;
      logic [31:0] mem_m  [2][32];
      logic        busy_m [2][32];
      logic [31:0] pd [3];
      logic        pb [3];
      int          we [2];
      int          wbk [2];
      int          wad [2];
      logic [31:0] wdt [2];
      int          mk, mbk, mad, rbk, rad;
      logic        st, bb;
      logic [31:0] ed;
      logic        eb;
      idle();
      rst_n = 1'b0;
      #1;
      rst_n = 1'b1;
      for (int b = 0; b < 2; b++) begin
         for (int r = 0; r < 32; r++) begin
            mem_m[b][r]  = '0;
            busy_m[b][r] = 1'b0;
         end
      end
      for (int p = 0; p < 3; p++) begin
         pd[p] = '0;
         pb[p] = 1'b0;
      end
      for (int s = 0; s < 120; s++) begin
         idle();
         st = ($urandom_range(0, 7) == 0);
         bb = ($urandom_range(0, 7) == 0);
         stall  = st;
         bubble = bb;
         for (int w = 0; w < 2; w++) begin
            we[w]  = int'($urandom_range(0, 1));
            wbk[w] = int'($urandom_range(0, 1));
            wad[w] = int'($urandom_range(0, 3));
            wdt[w] = $urandom;
            set_wr(w, we[w], wbk[w], wad[w], wdt[w]);
         end
         mk  = ($urandom_range(0, 2) == 0) ? 1 : 0;
         mbk = int'($urandom_range(0, 1));
         mad = int'($urandom_range(0, 3));
         set_mark(mk, mbk, mad);
         for (int p = 0; p < 3; p++) begin
            rbk = int'($urandom_range(0, 1));
            rad = int'($urandom_range(0, 3));
            set_rd(p, rbk, rad);
            ed = '0;
            eb = 1'b0;
            if (st) begin
               ed = pd[p];
               eb = pb[p];
            end else if (!bb) begin
               if (!(rbk == 0 && rad == 0)) begin
                  ed = mem_m[rbk][rad];
                  eb = busy_m[rbk][rad];
               end
               for (int w = 0; w < 2; w++) begin
                  if (we[w] != 0 && !(wbk[w] == 0 && wad[w] == 0) &&
                      wbk[w] == rbk && wad[w] == rad) begin
                     ed = wdt[w];
                     eb = 1'b0;
                  end
               end
            end
            pd[p] = ed;
            pb[p] = eb;
            exp_rd(0, p, 64'(ed), eb, "b2b");
         end
         if (!st) begin
            for (int w = 0; w < 2; w++) begin
               if (we[w] != 0 && !(wbk[w] == 0 && wad[w] == 0)) begin
                  mem_m[wbk[w]][wad[w]]  = wdt[w];
                  busy_m[wbk[w]][wad[w]] = 1'b0;
               end
            end
            if (mk != 0 && !(mbk == 0 && mad == 0)) busy_m[mbk][mad] = 1'b1;
         end
         tick();
         while (sb.size() > 0) begin
            e = sb.pop_front();
            tests++;
            if (get_d(e.inst, e.port) !== e.data || get_b(e.inst, e.port) !== e.busy) begin
               fails++;
               $display("FAIL %s step %0d port %0d: got data=%h busy=%b, want data=%h busy=%b",
                        e.name, s, e.port, get_d(e.inst, e.port), get_b(e.inst, e.port), e.data, e.busy);
            end
         end
      end
   endtask

   task automatic test_param_sweep();
      exp_t        e;
      logic [63:0] pat [3];
      int          b;
      pat[0] = 64'h0123456789ABCDEF;
      pat[1] = 64'hFEDCBA9876543210;
      pat[2] = 64'hA5A55A5AC3C33C3C;
      for (int s = 0; s < 8; s++) begin
         idle();
         if (s < 3) begin
            wr_en2   = 1'b1;
            wr_bank2 = 2'(s);
            wr_addr2 = 4'd15;
            wr_data2 = pat[s];
            rd_bank2[1:0] = 2'(s);
            rd_addr2[3:0] = 4'd15;
            rd_bank2[3:2] = 2'(s);
            rd_addr2[7:4] = 4'd14;
            exp_rd(1, 0, pat[s], 1'b0, "sweep_bypass");
            exp_rd(1, 1, 64'h0, 1'b0, "sweep_neighbour");
         end else if (s < 6) begin
            b = s - 3;
            rd_bank2[1:0] = 2'(b);
            rd_addr2[3:0] = 4'd15;
            rd_bank2[3:2] = 2'(b);
            rd_addr2[7:4] = 4'd15;
            exp_rd(1, 0, pat[b], 1'b0, "sweep_store0");
            exp_rd(1, 1, pat[b], 1'b0, "sweep_store1");
         end else if (s == 6) begin
            wr_en2     = 1'b1;
            wr_bank2   = 2'd3;
            wr_addr2   = 4'd15;
            wr_data2   = '1;
            mark_en2   = 1'b1;
            mark_bank2 = 2'd3;
            mark_addr2 = 4'd15;
            rd_bank2[1:0] = 2'd3;
            rd_addr2[3:0] = 4'd15;
            rd_bank2[3:2] = 2'd3;
            rd_addr2[7:4] = 4'd0;
            exp_rd(1, 0, 64'h0, 1'b0, "sweep_oob_bypass");
            exp_rd(1, 1, 64'h0, 1'b0, "sweep_oob_r0");
         end else begin
            rd_bank2[1:0] = 2'd3;
            rd_addr2[3:0] = 4'd15;
            rd_bank2[3:2] = 2'd2;
            rd_addr2[7:4] = 4'd15;
            exp_rd(1, 0, 64'h0, 1'b0, "sweep_oob_read");
            exp_rd(1, 1, pat[2], 1'b0, "sweep_no_alias");
         end
         tick();
         while (sb.size() > 0) begin
            e = sb.pop_front();
            tests++;
            if (get_d(e.inst, e.port) !== e.data || get_b(e.inst, e.port) !== e.busy) begin
               fails++;
               $display("FAIL %s step %0d port %0d: got data=%h busy=%b, want data=%h busy=%b",
                        e.name, s, e.port, get_d(e.inst, e.port), get_b(e.inst, e.port), e.data, e.busy);
            end
         end
      end
   endtask

   initial begin
      rst_n = 1'b0;
      idle();
      repeat (2) @(posedge clk);
      #1;
      test_reset();
      test_bypass();
      test_scoreboard();
      test_stall();
      test_bubble();
      test_back_to_back();
      test_param_sweep();
      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

endmodule
